// File: rtl/ecpa_pkg.sv
// Shared definitions for the ECPA limb-serial modular arithmetic blocks:
// the sequencer state encoding, default operand/limb widths and the
// helper that sizes the limb index counter.
package ecpa_pkg;

  localparam int DEFAULT_WIDTH = 256;
  localparam int DEFAULT_LIMB  = 64;

  // Sequencer states shared by the modular adder and subtractor.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Width of a counter that indexes n limbs (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ecpa_limb_addsub.sv
// Combinational LIMB-bit adder/subtractor.
//   i_sub = 0 : {o_cout, o_sum} = i_a + i_b + i_cin          (o_cout = carry)
//   i_sub = 1 : o_sum = i_a - i_b - i_cin, o_cout = borrow    (i_cin = borrow in)
// Subtraction reuses the adder: a - b - bin = a + ~b + ~bin, and the borrow
// out is the inverted carry out of that sum.
module ecpa_limb_addsub #(
  parameter int LIMB = 64
) (
  input  logic            i_sub,
  input  logic [LIMB-1:0] i_a,
  input  logic [LIMB-1:0] i_b,
  input  logic            i_cin,
  output logic [LIMB-1:0] o_sum,
  output logic            o_cout
);

  logic [LIMB-1:0] w_b_eff;
  logic            w_cin_eff;
  logic [LIMB:0]   w_full;

  // Single carry chain serves both modes; operands are conditioned first.
  always_comb begin
    w_b_eff   = i_sub ? ~i_b : i_b;
    w_cin_eff = i_sub ? ~i_cin : i_cin;
    w_full    = {1'b0, i_a} + {1'b0, w_b_eff} + {{LIMB{1'b0}}, w_cin_eff};
    o_sum     = w_full[LIMB-1:0];
    o_cout    = i_sub ? ~w_full[LIMB] : w_full[LIMB];
  end

endmodule

// File: rtl/modular_subtraction.sv
// Limb-serial modular subtractor: result = (A - B) mod p for A, B < p.
// A SUB pass walks the limbs LSB first with a borrow; if the final borrow
// is set, an ADD pass adds p back, discarding the final carry.
//
// Build option MODSUB_CONST_TIME_EN: when defined, the ADD pass always runs
// (adding p or 0) so the latency is 2N regardless of the operands.
//
// Handshake: i_start is a level request sampled only in IDLE; A, B and p are
// captured on the accepting edge. done rises when the result is ready and
// stays high, with result frozen, until i_start is seen low; done falls on
// that same edge and a new request can be accepted one IDLE cycle later.
// i_rst is synchronous, active-high and takes priority over everything.
//
// WIDTH must be a multiple of LIMB.
module modular_subtraction
  import ecpa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LIMB  = DEFAULT_LIMB
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output state_t           o_state
);

  localparam int N     = WIDTH / LIMB;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;     // minuend, shifted right one limb per SUB cycle
  logic [WIDTH-1:0] r_b;     // subtrahend, shifted with r_a
  logic [WIDTH-1:0] r_p;     // modulus, shifted right one limb per ADD cycle
  logic [WIDTH-1:0] r_res;   // result, limbs shifted in from the top
  logic [IDX_W-1:0] r_idx;   // current limb index within a pass
  logic             r_cy;    // borrow during SUB, carry during ADD
  logic             r_add_en; // final SUB borrow: add p (1) or 0 (0) in ADD

  logic             w_sub;
  logic             w_last;
  logic [LIMB-1:0]  w_op_a;
  logic [LIMB-1:0]  w_op_b;
  logic [LIMB-1:0]  w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  // Operand selection: SUB consumes A/B limbs, ADD re-reads the result limbs.
  always_comb begin
    w_sub      = (r_state == ST_SUB);
    w_last     = (r_idx == LAST_IDX);
    w_op_a     = w_sub ? r_a[LIMB-1:0] : r_res[LIMB-1:0];
    w_op_b     = w_sub ? r_b[LIMB-1:0]
                       : (r_add_en ? r_p[LIMB-1:0] : {LIMB{1'b0}});
    w_res_next = (r_res >> LIMB) | (WIDTH'(w_sum) << (WIDTH - LIMB));
  end

  ecpa_limb_addsub #(
    .LIMB (LIMB)
  ) u_limb (
    .i_sub  (w_sub),
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .i_cin  (r_cy),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_SUB;
      ST_SUB: begin
        if (w_last) begin
`ifdef MODSUB_CONST_TIME_EN
          w_next = ST_ADD;
`else
          w_next = w_cout ? ST_ADD : ST_DONE;
`endif
        end
      end
      ST_ADD:  if (w_last) w_next = ST_DONE;
      ST_DONE: if (!i_start) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, limb shifting, index and borrow/carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_cy     <= 1'b0;
      r_add_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a   <= A;
            r_b   <= B;
            r_p   <= p;
            r_idx <= '0;
            r_cy  <= 1'b0;
          end
        end
        ST_SUB: begin
          r_res <= w_res_next;
          r_a   <= r_a >> LIMB;
          r_b   <= r_b >> LIMB;
          if (w_last) begin
            r_idx    <= '0;
            r_cy     <= 1'b0;
            r_add_en <= w_cout;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            r_cy  <= w_cout;
          end
        end
        ST_ADD: begin
          r_res <= w_res_next;
          r_p   <= r_p >> LIMB;
          if (w_last) begin
            r_idx <= '0;
            r_cy  <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            r_cy  <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered state; result is frozen while in DONE.
  always_comb begin
    result  = r_res;
    done    = (r_state == ST_DONE);
    o_state = r_state;
  end

endmodule

// File: doc/modular_subtraction.md
# modular_subtraction

- Limb-serial modular subtractor for the ECPA datapath: computes result = (A − B) mod p for A, B < p.
- Inverse companion of the modular adder.
- Subtracts limb-by-limb with borrow propagation; when the final borrow is set, adds p back in a second limb-serial pass.
- Same start/done level handshake as the modular adder, so the point-arithmetic sequencer drives both identically.

## Interface
- WIDTH, 256, operand/modulus width in bits.
- LIMB, 64, bits processed per cycle; WIDTH must be a multiple of LIMB; N = WIDTH/LIMB.
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_start  in  1  level request; sampled only in IDLE.
- A  in  WIDTH  minuend; latched when start is accepted.
- B  in  WIDTH  subtrahend; latched when start is accepted.
- p  in  WIDTH  modulus; latched when start is accepted.
- result  out  WIDTH  (A − B) mod p; valid while done=1.
- done  out  1  result valid; held high until i_start drops.

## Operation
- States:
  - IDLE: i_start=1 latches A, B and p, clears the limb index and borrow, then goes to SUB.
  - SUB: each cycle writes r[i] = A[i] − B[i] − borrow and updates borrow.
    - After limb N−1 with final borrow=0: go to DONE.
    - After limb N−1 with final borrow=1: clear the carry and the limb index, then go to ADD.
  - ADD: each cycle writes r[i] = r[i] + p[i] + carry. The final carry-out is discarded, so the sum wraps mod 2^WIDTH. After limb N−1, go to DONE.
  - DONE: done=1 and result=r. Stay while i_start=1; go to IDLE when i_start=0. done falls on the same edge.
- i_start=1 in SUB or ADD is ignored. A, B and p may change after acceptance without effect.
- Arithmetic is exact WIDTH-bit two's-complement with a single borrow/carry bit per limb.
- Out-of-range operands (A≥p or B≥p) are not flagged. The output is still the deterministic result of the algorithm above.
- i_rst=1 in any state: next edge forces IDLE, result=0, done=0, limb index/borrow/carry=0. Any operation in flight is abandoned and no done is issued.
- i_rst has priority over i_start on the same edge.

## Timing
- Reset values: result=0, done=0, state IDLE.
- Edge 0 is the IDLE edge that samples i_start=1.
- No correction: limbs are written on edges 1..N. DONE is entered on edge N, so done=1 for the cycle after edge N (latency N).
- Correction: ADD limbs are written on edges N+1..2N, and done=1 after edge 2N (latency 2N).
- Restart: the earliest next acceptance is one IDLE cycle after i_start is seen low in DONE.
- result is registered and never changes while done=1.

## Configuration
- MODSUB_CONST_TIME_EN defined:
  - The ADD pass always runs, adding p when the final borrow=1 and 0 otherwise.
  - Latency is always 2N, independent of the data.
  - Intended for side-channel-resistant builds.
- Undefined: ADD is skipped when borrow=0, so latency is N or 2N.

## Structure
- Shared package ecpa_pkg holds:
  - the state enum (IDLE, SUB, ADD, DONE);
  - default WIDTH/LIMB constants;
  - the limb index width function clog2(N).
- One sub-module, ecpa_limb_addsub. It is a combinational LIMB-bit adder/subtractor with a mode bit, carry/borrow in and carry/borrow out. It is shared by the SUB and ADD passes.
- Top level contains the FSM, the operand shift/index registers and the result register.

## Test plan
All scenarios use WIDTH=256, LIMB=64 and MODSUB_CONST_TIME_EN undefined unless noted.
- A=0x123456789, B=0, p=0xfffffffff → result 0x123456789, done after 4 cycles.
- A=0x20, B=0xff, p=0x100 → result 0x21 (borrow, correction), done after 8 cycles.
- A=B=0xdeadbeef, p=0xffffffff → result 0, latency 4.
- Cross-limb borrow, A=2^64, B=1, p=2^255−19 → result 0xffffffffffffffff.
- A=0, B=1, p=2^255−19 → result 0x7fff…ffec, latency 8.
  - Rerun with MODSUB_CONST_TIME_EN: the first case must also take 8 cycles.
- Reset and handshake:
  - Assert i_rst on the 2nd SUB cycle → done=0 and result=0 next edge, no spurious done.
  - A following start completes normally.
  - Holding i_start keeps done=1; dropping it clears done on the next edge.
